channel_scan_sequencer: RTL and testbench
=========================================

Name: channel_scan_sequencer

Overview:
Upstream driver for the 8-channel transmission/distribution stage. It accepts an 8-bit channel-enable pattern through a valid/ready handshake. It then steps the 3-bit channel select {A,B,C} through channels 0..7, holding each channel for a programmable dwell time. For each channel it drives the matching one-hot-low data word into the distributor's data input. It replaces hand-written stimulus sequences with a reusable, clocked scan source.

Parameters:
DWELL, 4, clock cycles each channel is held (legal range 1..255)
CNT_W, 8, width of the dwell counter (must hold DWELL-1)

Ports:
iClk  input  1  system clock, all state changes on rising edge
iRst  input  1  synchronous active-high reset
iValid  input  1  pattern offer from control logic
iPattern  input  8  channel-enable mask; bit n=1 enables channel n
oReady  output  1  high when a new pattern can be accepted (IDLE only)
iContinuous  input  1  1 = repeat frame with latched pattern; sampled at frame wrap
iStop  input  1  abort the current scan
oA  output  1  channel select MSB (ch[2])
oB  output  1  channel select (ch[1])
oC  output  1  channel select LSB (ch[0])
oData  output  8  data word to distributor
oBusy  output  1  high while in SCAN
oFrameDone  output  1  one-cycle pulse at the end of a non-continuous frame

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (iRst high at an edge) sets: state=IDLE, ch=0, dwell counter=0, latched pattern=8'h00, oA/oB/oC=0, oData=8'hFF, oBusy=0, oFrameDone=0. oReady=1 from the first cycle after reset. Handshakes are ignored while iRst is high.
- Reset during SCAN abandons the frame immediately. No oFrameDone pulse.
- All outputs are registered except oReady, which is (state==IDLE).
- States:
  - IDLE: oBusy=0, oData=8'hFF, select=0.
  - SCAN: oBusy=1.
- IDLE -> SCAN on iValid && oReady && !iStop. The edge latches iPattern, sets ch=0 and cnt=0.
- Timing: if the handshake completes at edge k, channel 0 appears on outputs in the cycle after edge k.
- In SCAN:
  - {oA,oB,oC}=ch.
  - oData = ~(8'b1<<ch) if pattern[ch]=1, else 8'hFF. A disabled channel still occupies its dwell slot.
- Dwell counter: increments each cycle. When cnt==DWELL-1, cnt returns to 0 and ch advances by 1. Each channel is visible for exactly DWELL cycles, so a frame is 8*DWELL cycles.
- Frame wrap (cnt==DWELL-1 and ch==7):
  - iContinuous=1: ch wraps to 0 and the same pattern is reused. No oFrameDone, no gap cycle.
  - iContinuous=0: next state is IDLE, outputs go to idle values, and oFrameDone=1 for exactly one cycle, coincident with the first IDLE cycle.
- iStop in SCAN: on the next edge state=IDLE with idle outputs. No oFrameDone. iStop has priority over the frame-wrap action on the same edge.
- iStop in IDLE blocks acceptance of a simultaneous iValid.
- iValid is ignored in SCAN (oReady=0). The pattern cannot change mid-frame.
- A new handshake is accepted in the same cycle oFrameDone is high, because oReady=1 there. The new scan starts on the following edge, giving one idle cycle between frames.
- DWELL=1: channel advances every cycle; the wrap rules above are unchanged.
- iPattern=8'h00: full-length frame runs with oData=8'hFF throughout, select still steps.

Test Plan:
1. DWELL=2, reset 3 cycles, then iValid with iPattern=8'hFF, iContinuous=0.
   - oData sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 2 cycles.
   - {A,B,C} follows 000..111.
   - oFrameDone pulses once 16 cycles after the first channel cycle; oReady then returns to 1.
2. iPattern=8'hA5.
   - Channels 0,2,5,7 show one-hot-low words.
   - Channels 1,3,4,6 show FF while select still steps.
3. iContinuous=1 for 3 frames.
   - ch wraps 7->0 with no gap and no oFrameDone.
   - Drop iContinuous before the third wrap: exactly one oFrameDone, then IDLE.
4. iStop asserted at ch=3 mid-dwell.
   - Next cycle: IDLE, oData=FF, select=000, oBusy=0, no oFrameDone.
   - Repeat with iStop on the final wrap edge: still no pulse.
5. iRst asserted at ch=5 in SCAN.
   - Next cycle: all outputs at reset values, oReady=1.
   - An iValid held during reset is not accepted.
6. Back-to-back frames: iValid held high with pattern 8'h0F then 8'hF0.
   - Second frame accepted in the oFrameDone cycle and starts one cycle later.
   - iValid during SCAN is ignored.
   - With DWELL=1, each channel lasts exactly 1 cycle.

Source files
------------

// File: rtl/channel_scan_sequencer.sv
// channel_scan_sequencer: steps a 3-bit channel select through 0..7 with a fixed dwell per channel and drives one-hot-low data words
// iClk/iRst: clock and synchronous active-high reset
// iValid/iPattern/oReady: channel-enable pattern handshake, accepted only in IDLE
// iContinuous: repeat the frame at wrap; iStop: abort the scan
// oA/oB/oC: channel select MSB..LSB; oData: data word; oBusy: scanning; oFrameDone: end-of-frame pulse
module channel_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iValid,
  input  logic [7:0] iPattern,
  output logic       oReady,
  input  logic       iContinuous,
  input  logic       iStop,
  output logic       oA,
  output logic       oB,
  output logic       oC,
  output logic [7:0] oData,
  output logic       oBusy,
  output logic       oFrameDone
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);
  state_t state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] pat_q, pat_d, data_d;
  logic done_d;
  // ch is held at 0 whenever the state is IDLE, so the select outputs come straight from the register
  assign {oA, oB, oC} = ch_q;
  assign oBusy = state_q == SCAN;
  assign oReady = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    pat_d = pat_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (iValid && !iStop) begin
        state_d = SCAN;
        pat_d = iPattern;
        ch_d = 3'd0;
        cnt_d = '0;
      end
    end else if (iStop) begin
      state_d = IDLE;
      ch_d = 3'd0;
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      ch_d = ch_q + 3'd1;
      if (ch_q == 3'd7 && !iContinuous) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    data_d = (state_d == SCAN && pat_d[ch_d]) ? ~(8'b1 << ch_d) : 8'hFF;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      ch_q <= 3'd0;
      cnt_q <= '0;
      pat_q <= 8'h00;
      oData <= 8'hFF;
      oFrameDone <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      pat_q <= pat_d;
      oData <= data_d;
      oFrameDone <= done_d;
    end
  end
endmodule

// File: tb/tb_channel_scan_sequencer.sv
// tb_channel_scan_sequencer: checks DWELL=2 and DWELL=1 instances against a time-based reference model
module tb_channel_scan_sequencer;
  logic iClk = 1'b0, iRst = 1'b1, iValid = 1'b0, iContinuous = 1'b0, iStop = 1'b0;
  logic [7:0] iPattern = 8'h00;
  logic r2, a2, b2, c2, busy2, done2, r1, a1, b1, c1, busy1, done1;
  logic [7:0] data2, data1;
  int vectors = 0, miscompares = 0;
  always #5 iClk = ~iClk;
  channel_scan_sequencer #(.DWELL(2), .CNT_W(8)) dut2 (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iPattern(iPattern), .oReady(r2),
    .iContinuous(iContinuous), .iStop(iStop), .oA(a2), .oB(b2), .oC(c2),
    .oData(data2), .oBusy(busy2), .oFrameDone(done2));
  channel_scan_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iPattern(iPattern), .oReady(r1),
    .iContinuous(iContinuous), .iStop(iStop), .oA(a1), .oB(b1), .oC(c1),
    .oData(data1), .oBusy(busy1), .oFrameDone(done1));
  wire [12:0] g2 = {a2, b2, c2, data2, busy2, done2, r2};
  wire [12:0] g1 = {a1, b1, c1, data1, busy1, done1, r1};
  // Model: t counts cycles since the scan started; channel = t / dwell
  typedef struct {bit busy; int t; logic [7:0] pat; bit done;} model_t;
  model_t m2, m1;
  function automatic model_t step(model_t m, int d);
    if (iRst) begin
      m.busy = 0; m.t = 0; m.pat = 8'h00; m.done = 0;
    end else if (!m.busy) begin
      m.done = 0;
      if (iValid && !iStop) begin m.busy = 1; m.t = 0; m.pat = iPattern; end
    end else begin
      m.done = 0;
      if (iStop) m.busy = 0;
      else begin
        m.t++;
        if (m.t == 8 * d) begin
          m.t = 0;
          if (!iContinuous) begin m.busy = 0; m.done = 1; end
        end
      end
    end
    return m;
  endfunction
  function automatic logic [12:0] exp_out(model_t m, int d);
    int ch = m.busy ? m.t / d : 0;
    logic [7:0] w = (m.busy && m.pat[ch]) ? ~(8'h01 << ch) : 8'hFF;
    return {3'(ch), w, m.busy, m.done, !m.busy};
  endfunction
  always @(posedge iClk) begin
    m2 = step(m2, 2);
    m1 = step(m1, 1);
  end
  task automatic test_reset();
    iRst = 1; iValid = 1; iPattern = 8'hFF;
    repeat (3) begin
      @(negedge iClk); vectors++;
      if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
        miscompares++; $display("FAIL reset: got %h exp %h", {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
      end
    end
    vectors++;
    if ({r2, data2, busy2, done2, a2, b2, c2} !== {1'b1, 8'hFF, 1'b0, 1'b0, 3'b000}) begin
      miscompares++; $display("FAIL reset_values: got %h exp %h", {r2, data2, busy2, done2, a2, b2, c2}, {1'b1, 8'hFF, 5'b0});
    end
    iRst = 0; iValid = 0;
    @(negedge iClk); vectors++;
    if (busy2 !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid_ignored: busy %b%b exp 00", busy2, busy1);
    end
  endtask
  task automatic test_full_frame();
    int dones = 0, done_at = -1;
    iPattern = 8'hFF; iContinuous = 0; iValid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk); vectors++;
      if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
        miscompares++; $display("FAIL full_frame i=%0d: got %h exp %h", i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
      end
      if (done2) begin dones++; done_at = i; end
      iValid = 0;
    end
    vectors++;
    if (dones != 1 || done_at != 16) begin
      miscompares++; $display("FAIL frame_done_timing: got %0d pulses at %0d exp 1 at 16", dones, done_at);
    end
  endtask
  task automatic test_patterns();
    logic [7:0] pats [4];
    pats[0] = 8'hA5; pats[1] = 8'h00; pats[2] = 8'($urandom); pats[3] = 8'($urandom);
    for (int p = 0; p < 4; p++) begin
      iPattern = pats[p]; iValid = 1;
      for (int i = 0; i < 18; i++) begin
        @(negedge iClk); vectors++;
        if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
          miscompares++; $display("FAIL pattern %h i=%0d: got %h exp %h", pats[p], i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
        end
        iValid = 0;
      end
    end
  endtask
  task automatic test_continuous();
    int dones = 0;
    iPattern = 8'($urandom); iContinuous = 1; iValid = 1;
    for (int i = 0; i < 52; i++) begin
      @(negedge iClk); vectors++;
      if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
        miscompares++; $display("FAIL continuous i=%0d: got %h exp %h", i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
      end
      if (done2) dones++;
      iValid = 0;
      if (i == 40) iContinuous = 0;
    end
    vectors++;
    if (dones != 1) begin
      miscompares++; $display("FAIL continuous_done_count: got %0d exp 1", dones);
    end
  endtask
  task automatic test_stop();
    int stop_at [2];
    stop_at[0] = 6; stop_at[1] = 15;
    for (int s = 0; s < 2; s++) begin
      int dones = 0;
      iPattern = 8'($urandom); iValid = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge iClk); vectors++;
        if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
          miscompares++; $display("FAIL stop@%0d i=%0d: got %h exp %h", stop_at[s], i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
        end
        if (done2) dones++;
        iValid = 0;
        iStop = (i == stop_at[s]);
      end
      vectors++;
      if (dones != 0) begin
        miscompares++; $display("FAIL stop_no_done@%0d: got %0d pulses exp 0", stop_at[s], dones);
      end
    end
    iValid = 1; iStop = 1;
    @(negedge iClk); vectors++;
    if (busy2 !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++; $display("FAIL stop_blocks_valid: busy %b%b exp 00", busy2, busy1);
    end
    iValid = 0; iStop = 0;
  endtask
  task automatic test_reset_mid();
    iPattern = 8'hFF; iValid = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge iClk); vectors++;
      if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
        miscompares++; $display("FAIL reset_mid i=%0d: got %h exp %h", i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
      end
      if (i == 11 && {r2, data2, busy2, done2, a2, b2, c2} !== {1'b1, 8'hFF, 5'b0}) begin
        miscompares++; $display("FAIL reset_mid_values: got %h exp %h", {r2, data2, busy2, done2, a2, b2, c2}, {1'b1, 8'hFF, 5'b0});
      end
      iValid = (i == 10);
      iRst = (i == 10);
    end
  endtask
  task automatic test_back_to_back();
    iPattern = 8'h0F; iValid = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk); vectors++;
      if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
        miscompares++; $display("FAIL back_to_back i=%0d: got %h exp %h", i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
      end
      if (i == 16 && {done2, r2, busy2} !== 3'b110) begin
        miscompares++; $display("FAIL b2b_done_cycle: got %b exp 110", {done2, r2, busy2});
      end
      if (i == 17 && {busy2, a2, b2, c2, data2} !== {4'b1000, 8'hFF}) begin
        miscompares++; $display("FAIL b2b_restart: got %h exp %h", {busy2, a2, b2, c2, data2}, {4'b1000, 8'hFF});
      end
      if (i == 10) iPattern = 8'hF0;
      if (i == 30) iValid = 0;
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge iClk); vectors++;
      if ({g2, g1} !== {exp_out(m2, 2), exp_out(m1, 1)}) begin
        miscompares++; $display("FAIL random i=%0d: got %h exp %h", i, {g2, g1}, {exp_out(m2, 2), exp_out(m1, 1)});
      end
      iValid = ($urandom % 3) == 0;
      iPattern = 8'($urandom);
      iStop = ($urandom % 24) == 0;
      iContinuous = ($urandom % 2) == 0;
      iRst = ($urandom % 80) == 0;
    end
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_patterns();
    test_continuous();
    test_stop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
